data_sram_responder: RTL and testbench

- Slave/responder end of the CPU data-SRAM-like bus: accepts load and store requests from the pipeline (EXE issues, MEM consumes the response) and completes them in order after a fixed latency.
- Holds a word-organised memory and returns the raw 32-bit word on reads. Byte/halfword extraction and sign extension stay in the MEM stage.
- Used as the simulation and FPGA data memory in place of the single-cycle synchronous RAM.

---
 rtl/data_sram_responder.sv | 170 +++++++++++++++++
 tb/tb_data_sram_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Responder end of the CPU data-SRAM-like bus. Load/store requests are queued
// in a small FIFO and completed strictly in order, a fixed number of cycles
// after each one becomes queue head. Loads return the raw 32-bit word. Stores
// write the byte lanes selected by wstrb.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (memory contents are kept)
//   req      request valid
//   wr       1 = store, 0 = load
//   size     access size (recorded only, has no effect)
//   addr     byte address; word index = addr[ADDR_WIDTH+1:2]
//   wstrb    byte-lane write enables for stores
//   wdata    lane-aligned store data
//   addr_ok  request accepted when req & addr_ok
//   data_ok  one-cycle completion pulse per accepted request, in order
//   rdata    loaded word, valid in the data_ok cycle of a load
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0]    LAT3 = 3'(LATENCY);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] idx;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
    } entry_t;

    entry_t      fifo_mem [DEPTH];
    logic [31:0] mem      [2**ADDR_WIDTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ctr_q, ctr_d;
    logic          data_ok_q, data_ok_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          addr_ok_q, addr_ok_d;

    logic   push_s;
    logic   retire_s;
    entry_t head_s;
    entry_t new_s;
    logic   unused_s;

    assign push_s   = req & addr_ok_q;
    // ctr_q == 0 with a non-empty queue means the next entry is waiting one
    // cycle before it starts counting.
    assign retire_s = (cnt_q != {CW{1'b0}}) & (ctr_q == LAT3);
    assign head_s   = fifo_mem[rptr_q];

    assign new_s.wr    = wr;
    assign new_s.size  = size;
    assign new_s.idx   = addr[ADDR_WIDTH+1:2];
    assign new_s.wstrb = wstrb;
    assign new_s.wdata = wdata;

    // Address bits above the index alias. Size is carried but never used.
    assign unused_s = &{1'b0, addr[31:ADDR_WIDTH+2], addr[1:0], head_s.size};

    // Next-state computation for queue pointers, head counter and outputs.
    always_comb begin
        wptr_d    = push_s   ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = retire_s ? rptr_q + PW'(1) : rptr_q;
        cnt_d     = cnt_q;
        ctr_d     = ctr_q;
        data_ok_d = retire_s;
        rdata_d   = rdata_q;

        case ({push_s, retire_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (retire_s) begin
            // A push that lands as the only entry retires becomes head now;
            // otherwise the follower starts counting on the next edge.
            if ((cnt_q == CW'(1)) && push_s) begin
                ctr_d = 3'd1;
            end else begin
                ctr_d = 3'd0;
            end
        end else if (ctr_q == 3'd0) begin
            if ((cnt_q != {CW{1'b0}}) || push_s) begin
                ctr_d = 3'd1;
            end else begin
                ctr_d = 3'd0;
            end
        end else if (ctr_q != LAT3) begin
            ctr_d = ctr_q + 3'd1;
        end else begin
            ctr_d = ctr_q;
        end

        if (retire_s && !head_s.wr) begin
            rdata_d = mem[head_s.idx];
        end else begin
            rdata_d = rdata_q;
        end

        // Registered from next count: a slot freed at an edge shows up only
        // in the cycle after that edge.
        addr_ok_d = (cnt_d != FULL);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q    <= {PW{1'b0}};
            rptr_q    <= {PW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            ctr_q     <= 3'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            addr_ok_q <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ctr_q     <= ctr_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            addr_ok_q <= addr_ok_d;
        end
    end

    // Queue storage; slots are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wptr_q] <= new_s;
        end
    end

    // Word memory: byte-lane store at the retire edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && retire_s && head_s.wr) begin
            for (int k = 0; k < 4; k++) begin
                if (head_s.wstrb[k]) begin
                    mem[head_s.idx][8*k +: 8] <= head_s.wdata[8*k +: 8];
                end
            end
        end
    end

    assign addr_ok = addr_ok_q;
    assign data_ok = data_ok_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic        wr_s;
    logic [1:0]  size_s;
    logic [31:0] addr_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    logic        addr_ok0, addr_ok1;
    logic        data_ok0, data_ok1;
    logic [31:0] rdata0, rdata1;

    int checks;
    int failures;
    bit sel_v;

    logic        ok_m, dok_m;
    logic [31:0] rd_m;
    assign ok_m  = sel_v ? addr_ok1 : addr_ok0;
    assign dok_m = sel_v ? data_ok1 : data_ok0;
    assign rd_m  = sel_v ? rdata1   : rdata0;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req(req0), .wr(wr_s), .size(size_s),
        .addr(addr_s), .wstrb(wstrb_s), .wdata(wdata_s),
        .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0)
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .wr(wr_s), .size(size_s),
        .addr(addr_s), .wstrb(wstrb_s), .wdata(wdata_s),
        .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at negedges until the selected data_ok is high.
    task automatic wait_dok(output int n);
        n = 0;
        while (dok_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One request into an idle responder; checks latency and pulse width.
    task automatic issue_one(input bit sel, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] d,
                             output logic [31:0] rd);
        int lat;
        sel_v = sel;
        @(negedge clk);
        wr_s = w; addr_s = a; wstrb_s = s; wdata_s = d; size_s = 2'd2;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        chk("addr_ok_idle", {31'd0, ok_m}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_dok(lat);
        chk("latency", lat, sel ? 32'd1 : 32'd2);
        rd = rd_m;
        @(negedge clk);
        chk("pulse_one_cycle", {31'd0, dok_m}, 32'd0);
    endtask

    logic [31:0] rd;
    int n, acc, got, maxout, cyc, drop_acc, extra;
    bit pending, prev_ok, rise_checked;

    initial begin
        checks = 0; failures = 0; sel_v = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr_s = 1'b0; size_s = 2'd0;
        addr_s = 32'd0; wstrb_s = 4'd0; wdata_s = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_addr_ok", {31'd0, addr_ok0}, 32'd1);
        chk("rst_data_ok", {31'd0, data_ok0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_addr_ok_l1", {31'd0, addr_ok1}, 32'd1);

        // Store then load.
        issue_one(1'b0, 1'b1, 32'h1C, 4'hF, 32'hDEAD_BEEF, rd);
        issue_one(1'b0, 1'b0, 32'h1C, 4'h0, 32'h0, rd);
        chk("store_load", rd, 32'hDEAD_BEEF);

        // Partial writes and an empty-strobe store.
        issue_one(1'b0, 1'b1, 32'h40, 4'hF, 32'h1122_3344, rd);
        issue_one(1'b0, 1'b1, 32'h40, 4'b0100, 32'h00AA_0000, rd);
        issue_one(1'b0, 1'b1, 32'h40, 4'b0001, 32'h0000_00BB, rd);
        issue_one(1'b0, 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, rd);
        chk("store_keeps_rdata", rd, 32'hDEAD_BEEF);
        issue_one(1'b0, 1'b0, 32'h40, 4'h0, 32'h0, rd);
        chk("partial_write", rd, 32'h11AA_33BB);

        // Read-after-write with both requests queued.
        sel_v = 1'b0;
        @(negedge clk);
        wr_s = 1'b1; addr_s = 32'h80; wstrb_s = 4'hF; wdata_s = 32'h5A5A_5A5A; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("raw_ok2", {31'd0, addr_ok0}, 32'd1);
        wr_s = 1'b0; wstrb_s = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        wait_dok(n);
        chk("raw_store_lat", n, 32'd1);
        @(negedge clk);
        wait_dok(n);
        chk("raw_load_gap", n, 32'd2);
        chk("raw_rdata", rdata0, 32'h5A5A_5A5A);

        // Back-pressure: six loads with req held high.
        for (int i = 0; i < 6; i++) begin
            issue_one(1'b0, 1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), rd);
        end
        sel_v = 1'b0;
        acc = 0; got = 0; maxout = 0; cyc = 0; drop_acc = -1;
        prev_ok = 1'b1; rise_checked = 1'b0;
        @(negedge clk);
        wr_s = 1'b0; wstrb_s = 4'h0; addr_s = 32'h200; req0 = 1'b1;
        pending = req0 & addr_ok0;
        while (got < 6 && cyc < 100) begin
            @(posedge clk);
            if (pending) acc++;
            @(negedge clk);
            cyc++;
            if (data_ok0) begin
                chk("bp_rdata_order", rdata0, 32'hA000_0000 + 32'(got));
                got++;
            end
            if (acc - got > maxout) maxout = acc - got;
            if (!addr_ok0 && prev_ok && drop_acc < 0) drop_acc = acc;
            if (addr_ok0 && !prev_ok && !rise_checked) begin
                chk("bp_rise_with_retire", {31'd0, data_ok0}, 32'd1);
                rise_checked = 1'b1;
            end
            prev_ok = addr_ok0;
            req0 = (acc < 6);
            addr_s = 32'h200 + 32'(4 * acc);
            pending = req0 & addr_ok0;
        end
        req0 = 1'b0;
        chk("bp_responses", got, 32'd6);
        chk("bp_accepts", acc, 32'd6);
        chk("bp_drop_after", drop_acc, 32'd5);
        chk("bp_max_outstanding", maxout, 32'd4);
        chk("bp_rise_seen", {31'd0, rise_checked}, 32'd1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_ok0) extra++;
        end
        chk("bp_no_duplicates", extra, 32'd0);

        // Reset with a store still queued.
        issue_one(1'b0, 1'b1, 32'h100, 4'hF, 32'h1234_5678, rd);
        issue_one(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, rd);
        chk("pre_reset_rdata", rd, 32'hA000_0000);
        @(negedge clk);
        wr_s = 1'b1; addr_s = 32'h100; wstrb_s = 4'hF; wdata_s = 32'h0F0F_0F0F; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_s = 1'b0; wstrb_s = 4'h0;
        @(posedge clk);
        @(negedge clk);
        addr_s = 32'h104; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req0 = 1'b0;
        chk("midrst_addr_ok", {31'd0, addr_ok0}, 32'd1);
        chk("midrst_data_ok", {31'd0, data_ok0}, 32'd0);
        chk("midrst_rdata", rdata0, 32'd0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (data_ok0) extra++;
        end
        chk("midrst_dropped", extra, 32'd0);
        issue_one(1'b0, 1'b0, 32'h100, 4'h0, 32'h0, rd);
        chk("midrst_mem_kept", rd, 32'h1234_5678);

        // Aliasing on the LATENCY=1 instance.
        issue_one(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, rd);
        issue_one(1'b1, 1'b0, 32'h0000, 4'h0, 32'h0, rd);
        chk("alias_l1", rd, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
